// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: locks onto a VGA sync stream, recovers pixel coordinates,
// flags timing/blanking violations and captures one probe pixel per frame.
module vga_sync_monitor #(
    parameter int H_TOTAL      = 2160,
    parameter int H_SYNC_START = 64,
    parameter int H_SYNC_END   = 255,
    parameter int H_VIS_START  = 560,
    parameter int V_TOTAL      = 1250,
    parameter int V_SYNC_START = 1,
    parameter int V_SYNC_END   = 3,
    parameter int V_VIS_START  = 50
) (
    input  logic        clock_162,
    input  logic        rst,
    input  logic [3:0]  RED,
    input  logic [3:0]  GREEN,
    input  logic [3:0]  BLUE,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic [10:0] probe_x,
    input  logic [10:0] probe_y,
    output logic        locked,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        sync_err,
    output logic [7:0]  err_count,
    output logic        blank_err,
    output logic [11:0] probe_rgb,
    output logic        probe_done
);
    localparam logic [11:0] HT  = 12'(H_TOTAL);
    localparam logic [11:0] HSS = 12'(H_SYNC_START);
    localparam logic [11:0] HSE = 12'(H_SYNC_END);
    localparam logic [11:0] HVS = 12'(H_VIS_START);
    localparam logic [10:0] VT  = 11'(V_TOTAL);
    localparam logic [10:0] VSS = 11'(V_SYNC_START);
    localparam logic [10:0] VSE = 11'(V_SYNC_END);
    localparam logic [10:0] VVS = 11'(V_VIS_START);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
    state_t state_q, state_d;

    logic [11:0] rgb1_q;
    logic        hs1_q, vs1_q, vs_prev_q;
    logic [11:0] col_q, col_d, cur_col;
    logic [10:0] row_q, row_d, cur_row;
    logic [10:0] probe_x_q, probe_y_q;
    logic        probe_hit_q;

    logic        locked_q, pix_valid_q, frame_start_q, sync_err_q, blank_err_q, probe_done_q;
    logic [10:0] pix_x_q, pix_y_q;
    logic [11:0] pix_rgb_q, probe_rgb_q;
    logic [7:0]  err_count_q;

    logic exp_hs, exp_vs, vfall, mismatch, load, origin, live, visible, vis, fs, hit;
    logic [10:0] x, y;

    assign exp_hs   = !(col_q >= HSS && col_q <= HSE);
    assign exp_vs   = !(row_q >= VSS && row_q <= VSE);
    assign vfall    = vs_prev_q && !vs1_q;
    assign mismatch = (state_q != SEARCH) && ((hs1_q != exp_hs) || (vs1_q != exp_vs));
    assign load     = vfall && (state_q == SEARCH || mismatch);
    assign origin   = (col_q == 12'd0) && (row_q == VSS);
    assign live     = (state_d == LOCKED);
    assign visible  = (col_q >= HVS) && (row_q >= VVS);
    assign vis      = live && visible;
    assign fs       = live && origin;
    assign x        = 11'(col_q - HVS);
    assign y        = row_q - VVS;
    assign hit      = vis && (x == probe_x_q) && (y == probe_y_q) && !probe_hit_q;

    // A VSYNC fall both (re)defines the current sample's coordinates and restarts alignment.
    always_comb begin
        state_d = load ? ALIGN : mismatch ? SEARCH : (state_q == ALIGN && origin) ? LOCKED : state_q;
        cur_col = load ? 12'd0 : col_q;
        cur_row = load ? VSS : row_q;
        col_d   = (cur_col == HT - 12'd1) ? 12'd0 : cur_col + 12'd1;
        row_d   = (cur_col != HT - 12'd1) ? cur_row : (cur_row == VT - 11'd1) ? 11'd0 : cur_row + 11'd1;
    end

    always_ff @(posedge clock_162 or posedge rst) begin
        if (rst) begin
            rgb1_q        <= '0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            vs_prev_q     <= 1'b1;
            state_q       <= SEARCH;
            col_q         <= '0;
            row_q         <= '0;
            probe_x_q     <= '0;
            probe_y_q     <= '0;
            probe_hit_q   <= 1'b0;
            locked_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            err_count_q   <= '0;
            blank_err_q   <= 1'b0;
            probe_rgb_q   <= '0;
            probe_done_q  <= 1'b0;
        end else begin
            rgb1_q        <= {RED, GREEN, BLUE};
            hs1_q         <= HSYNC;
            vs1_q         <= VSYNC;
            vs_prev_q     <= vs1_q;
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            locked_q      <= live;
            pix_valid_q   <= vis;
            frame_start_q <= fs;
            sync_err_q    <= mismatch;
            probe_done_q  <= hit;
            probe_hit_q   <= fs ? 1'b0 : (probe_hit_q || hit);
            if (vis) begin
                pix_x_q   <= x;
                pix_y_q   <= y;
                pix_rgb_q <= rgb1_q;
            end
            if (fs) begin
                probe_x_q <= probe_x;
                probe_y_q <= probe_y;
            end
            if (hit) probe_rgb_q <= rgb1_q;
            if (mismatch && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            if (live && !visible && rgb1_q != 12'd0) blank_err_q <= 1'b1;
        end
    end

    assign locked      = locked_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
    assign err_count   = err_count_q;
    assign blank_err   = blank_err_q;
    assign probe_rgb   = probe_rgb_q;
    assign probe_done  = probe_done_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed checks of lock, pixel recovery, probe, blanking and
// error handling on a scaled-down 16x10 timing (visible 10x6, 160-sample frames).
module tb_vga_sync_monitor;
    localparam int HT = 16, HSS = 1, HSE = 2, HVS = 6;
    localparam int VT = 10, VSS = 1, VSE = 2, VVS = 4;
    localparam int GLITCH = 915, BLANK = 698;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  RED, GREEN, BLUE;
    logic        HSYNC, VSYNC;
    logic [10:0] probe_x, probe_y;
    logic        locked, pix_valid, frame_start, sync_err, blank_err, probe_done;
    logic [10:0] pix_x, pix_y;
    logic [11:0] pix_rgb, probe_rgb;
    logic [7:0]  err_count;

    int n_chk = 0, n_fail = 0;
    int sidx = 0;
    bit manual = 1'b0;
    int cnt_pv = 0, cnt_pd = 0, cnt_fs = 0, cnt_se = 0;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_VIS_START(HVS),
        .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_VIS_START(VVS)
    ) dut (
        .clock_162(clk), .rst(rst), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .probe_x(probe_x), .probe_y(probe_y),
        .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_start(frame_start), .sync_err(sync_err),
        .err_count(err_count), .blank_err(blank_err), .probe_rgb(probe_rgb),
        .probe_done(probe_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives stream sample sidx, then returns 1ns after the edge; outputs then reflect sample sidx-2.
    task automatic tick();
        int h, v, x, y;
        logic [11:0] c;
        h = sidx % HT;
        v = (sidx / HT) % VT;
        if (!manual) begin
            HSYNC = !(h >= HSS && h <= HSE) ^ (sidx == GLITCH);
            VSYNC = !(v >= VSS && v <= VSE);
            c = 12'h000;
            if (h >= HVS && v >= VVS) begin
                x = h - HVS;
                y = v - VVS;
                c = {4'h1, 4'(x), 4'(y)};
                if (x == 0 && y == 0) c = 12'hF00;
                if (x == 9 && y == 5) c = 12'h0F0;
            end
            if (sidx == BLANK) c = 12'h001;
            {RED, GREEN, BLUE} = c;
        end
        sidx++;
        @(posedge clk);
        #1;
        cnt_pv += int'(pix_valid);
        cnt_pd += int'(probe_done);
        cnt_fs += int'(frame_start);
        cnt_se += int'(sync_err);
    endtask

    task automatic run_to(input int t);
        while (sidx - 2 < t) tick();
    endtask

    task automatic zero_cnt();
        cnt_pv = 0; cnt_pd = 0; cnt_fs = 0; cnt_se = 0;
    endtask

    initial begin
        rst = 1'b1; HSYNC = 1'b1; VSYNC = 1'b1; {RED, GREEN, BLUE} = 12'h000;
        probe_x = 11'd9; probe_y = 11'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_locked", locked, 0);
        chk("reset_pix_valid", pix_valid, 0);
        chk("reset_err_count", err_count, 0);
        chk("reset_probe_rgb", probe_rgb, 0);
        chk("reset_blank_err", blank_err, 0);
        rst = 1'b0;

        run_to(16);
        chk("vfall_no_lock", locked, 0);
        run_to(175);
        chk("prelock_locked", locked, 0);
        zero_cnt();
        run_to(176);
        chk("lock_rise", locked, 1);
        chk("lock_frame_start", frame_start, 1);
        chk("lock_err_count", err_count, 0);
        run_to(229);
        chk("pre_vis_valid", pix_valid, 0);
        run_to(230);
        chk("p00_valid", pix_valid, 1);
        chk("p00_x", pix_x, 0);
        chk("p00_y", pix_y, 0);
        chk("p00_rgb", pix_rgb, 12'hF00);
        run_to(265);
        chk("p32_x", pix_x, 3);
        chk("p32_y", pix_y, 2);
        chk("p32_rgb", pix_rgb, 12'h132);
        run_to(272);
        chk("hold_valid", pix_valid, 0);
        chk("hold_x", pix_x, 9);
        chk("hold_y", pix_y, 2);
        chk("hold_rgb", pix_rgb, 12'h192);
        run_to(318);
        chk("probe_not_yet", probe_done, 0);
        run_to(319);
        chk("probe_done_f1", probe_done, 1);
        chk("probe_rgb_f1", probe_rgb, 12'h0F0);
        run_to(335);
        chk("frame_pv_count", cnt_pv, 60);
        chk("frame_fs_count", cnt_fs, 1);
        chk("frame_pd_count", cnt_pd, 1);
        run_to(336);
        chk("frame_start_f2", frame_start, 1);

        run_to(340);
        probe_x = 11'd2; probe_y = 11'd1;
        run_to(408);
        chk("probe_change_deferred", probe_done, 0);
        run_to(479);
        chk("probe_done_f2", probe_done, 1);
        chk("probe_rgb_f2", probe_rgb, 12'h0F0);
        run_to(568);
        chk("probe_done_f3", probe_done, 1);
        chk("probe_rgb_f3", probe_rgb, 12'h121);

        run_to(600);
        probe_x = 11'd10; probe_y = 11'd0;
        run_to(655);
        zero_cnt();
        run_to(697);
        chk("blank_before", blank_err, 0);
        run_to(698);
        chk("blank_set", blank_err, 1);
        chk("blank_locked", locked, 1);
        run_to(815);
        chk("blank_sticky", blank_err, 1);
        chk("probe_oor_count", cnt_pd, 0);
        chk("frame4_fs_count", cnt_fs, 1);
        chk("frame4_err_count", err_count, 0);

        run_to(914);
        chk("preglitch_locked", locked, 1);
        chk("preglitch_sync_err", sync_err, 0);
        run_to(915);
        chk("glitch_sync_err", sync_err, 1);
        chk("glitch_locked", locked, 0);
        chk("glitch_err_count", err_count, 1);
        run_to(916);
        chk("glitch_pulse_end", sync_err, 0);
        run_to(976);
        chk("realign_no_lock", locked, 0);
        chk("realign_no_fs", frame_start, 0);
        run_to(1135);
        chk("relock_pre", locked, 0);
        run_to(1136);
        chk("relock", locked, 1);
        chk("relock_fs", frame_start, 1);
        chk("relock_err_count", err_count, 1);
        chk("relock_blank", blank_err, 1);

        run_to(1200);
        rst = 1'b1;
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_err", err_count, 0);
        chk("async_rst_blank", blank_err, 0);
        chk("async_rst_probe_rgb", probe_rgb, 0);
        chk("async_rst_pix_x", pix_x, 0);
        rst = 1'b0;
        run_to(1295);
        chk("post_rst_search", locked, 0);
        run_to(1455);
        chk("post_rst_align", locked, 0);
        run_to(1456);
        chk("post_rst_lock", locked, 1);
        chk("post_rst_err", err_count, 0);

        manual = 1'b1;
        HSYNC = 1'b1;
        zero_cnt();
        for (int i = 0; i < 350; i++) begin
            VSYNC = 1'b1;
            tick();
            VSYNC = 1'b0;
            tick();
        end
        chk("inject_sync_err_count", cnt_se, 350);
        chk("inject_err_sat", err_count, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side checker for the 1600x1200@60 VGA stream our display driver emits; sits on the same clock_162 domain, tapping RED/GREEN/BLUE/HSYNC/VSYNC.
- Locks onto the sync pulses and recovers pixel coordinates. Flags timing violations and non-black blanking. Captures one programmable probe pixel per frame.
- Used in hardware self-test and as a bench scoreboard front-end.

Parameters:
- H_TOTAL, 2160, columns per line
- H_SYNC_START, 64, first column with HSYNC low
- H_SYNC_END, 255, last column with HSYNC low
- H_VIS_START, 560, first visible column (visible through H_TOTAL-1)
- V_TOTAL, 1250, lines per frame
- V_SYNC_START, 1, first line with VSYNC low
- V_SYNC_END, 3, last line with VSYNC low
- V_VIS_START, 50, first visible line (visible through V_TOTAL-1)

Ports:
- clock_162  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- RED  in  4  sampled red
- GREEN  in  4  sampled green
- BLUE  in  4  sampled blue
- HSYNC  in  1  horizontal sync, active-low
- VSYNC  in  1  vertical sync, active-low
- probe_x  in  11  visible column to capture, 0..1599
- probe_y  in  11  visible line to capture, 0..1199
- locked  out  1  high in LOCKED state
- pix_valid  out  1  recovered sample is visible and locked
- pix_x  out  11  visible column of recovered sample
- pix_y  out  11  visible line of recovered sample
- pix_rgb  out  12  {R,G,B} of recovered sample
- frame_start  out  1  one-cycle pulse per locked frame
- sync_err  out  1  one-cycle pulse on timing mismatch
- err_count  out  8  saturating count of sync_err pulses
- blank_err  out  1  sticky: nonzero RGB seen in blanking while locked
- probe_rgb  out  12  last captured probe pixel
- probe_done  out  1  one-cycle pulse when probe_rgb updates

Behaviour:
- Reset (async, rst high): state=SEARCH. All outputs 0. Internal col/row counters 0. Previous-VSYNC register 1.
- Stage 1 registers the inputs every cycle. Stage 2 registers all outputs. An input presented before edge N appears on the outputs after edge N+1, i.e. 2-cycle latency.
- VSYNC fall = stage-1 VSYNC 0 with the previous stage-1 VSYNC 1. That sample is defined as col=0, row=V_SYNC_START.
- Counters (12b col, 11b row) advance once per sample. col wraps H_TOTAL-1 -> 0 and row increments on that wrap. row wraps V_TOTAL-1 -> 0.
- Expected HSYNC = ~(H_SYNC_START <= col <= H_SYNC_END). Expected VSYNC = ~(V_SYNC_START <= row <= V_SYNC_END).
- SEARCH:
  - No checking; locked=0; pix_valid=0.
  - On VSYNC fall, load col=0, row=V_SYNC_START and go to ALIGN.
- ALIGN:
  - Compare both syncs with expected every sample.
  - Any mismatch: sync_err pulse, err_count++ (saturating at 255), go to SEARCH. A mismatch that is itself a VSYNC fall reloads and re-enters ALIGN in the same cycle.
  - On the sample with col=0 and row=V_SYNC_START (one full frame clean): go to LOCKED.
- LOCKED:
  - Same compare and mismatch rule as ALIGN.
  - frame_start pulses on each sample with col=0 and row=V_SYNC_START.
  - pix_valid=1 when col>=H_VIS_START and row>=V_VIS_START. Then pix_x=col-H_VIS_START, pix_y=row-V_VIS_START, pix_rgb={R,G,B}.
  - When pix_valid=0, pix_x/pix_y/pix_rgb hold their last value.
  - Nonzero RGB outside the visible window sets blank_err. It stays set until reset.
  - When a visible sample has pix_x==probe_x and pix_y==probe_y: probe_rgb<=RGB and probe_done pulses, at most once per frame.
  - probe_x/probe_y are sampled at frame_start, so changes mid-frame apply next frame.
  - Out-of-range probe coordinates never match.
- locked drops in the same output cycle that sync_err pulses.
- Reset mid-frame returns to SEARCH. Relock needs a VSYNC fall plus one clean frame, about 2.7M cycles.

Test Plan:
- Driver-exact stream from reset: first VSYNC fall at sample s -> locked rises after sample s+2,700,000 (+2 latency); frame_start every 2,700,000 cycles; err_count=0.
- Locked, pixel (0,0) driven RGB=12'hF00 -> pix_valid with pix_x=0, pix_y=0, pix_rgb=12'hF00; pix_valid high exactly 1,920,000 cycles per frame.
- probe=(1599,1199), last visible pixel=12'h0F0 -> probe_rgb=12'h0F0 and probe_done one pulse per frame; probe changed mid-frame takes effect next frame.
- Locked, HSYNC held low one extra cycle (col 256) -> one sync_err pulse, locked=0, err_count=1, relock after next VSYNC fall plus one frame.
- Locked, RGB=12'h001 at col 300 of a blanking line -> blank_err=1 and stays set; locked stays 1.
- rst asserted mid-frame while locked -> all outputs 0 immediately (async); after release the monitor stays in SEARCH until a VSYNC fall; 300 injected errors -> err_count=255.
